// File: rtl/edge_blip_pkg.sv
// Shared constants and helpers for the edge blip bank: edge-mode codes,
// parameter limits and the edge/mode match used by every channel.
package edge_blip_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int MAX_NCH         = 32;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_DB_CYCLES   = 255;

  // True when a transition in the given direction should raise a blip.
  function automatic logic edge_match(input int mode, input logic rising);
    return (mode == EDGE_BOTH) ||
           ((mode == EDGE_RISE) && rising) ||
           ((mode == EDGE_FALL) && !rising);
  endfunction

endpackage

// File: rtl/edge_blip_chan.sv
// One channel: synchroniser chain, debounce counter, registered edge blip
// and sticky pending flag.
module edge_blip_chan
  import edge_blip_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  input  logic en_i,
  input  logic clr_i,
  output logic level_o,
  output logic blip_o,
  output logic pending_o
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   blip_q, blip_d;
  logic                   pend_q, pend_d;
  logic                   synced;
  logic                   toggle;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    toggle  = 1'b0;
    // Any sample agreeing with the accepted level restarts the hold count.
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
      toggle  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    blip_d = toggle & en_i & edge_match(EDGE_MODE, ~level_q);
    // A new blip beats a same-cycle clear.
    pend_d = blip_d | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      blip_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      blip_q  <= blip_d;
      pend_q  <= pend_d;
    end
  end

  assign level_o   = level_q;
  assign blip_o    = blip_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/edge_blip_bank.sv
// Bank of NCH independent debounced edge detectors plus a combined
// any-blip indication taken straight from the registered blip vector.
module edge_blip_bank
  import edge_blip_pkg::*;
#(
  parameter int NCH         = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic [NCH-1:0] inLevel,
  input  logic [NCH-1:0] chanEn,
  input  logic [NCH-1:0] clrPend,
  output logic [NCH-1:0] levelOut,
  output logic [NCH-1:0] blip,
  output logic [NCH-1:0] pending,
  output logic           anyBlip
);

  if (NCH < 1 || NCH > MAX_NCH ||
      SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC_STAGES ||
      DB_CYCLES < 1 || DB_CYCLES > MAX_DB_CYCLES ||
      EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_param
    $error("edge_blip_bank: parameter out of range");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    edge_blip_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_chan (
      .clk_i    (clk),
      .rst_ni   (resetN),
      .in_i     (inLevel[i]),
      .en_i     (chanEn[i]),
      .clr_i    (clrPend[i]),
      .level_o  (levelOut[i]),
      .blip_o   (blip[i]),
      .pending_o(pending[i])
    );
  end

  assign anyBlip = |blip;

endmodule

// File: tb/tb_edge_blip_bank.sv
// Bench for edge_blip_bank: three differently parameterised banks share one
// stimulus stream and are compared against a sample-history reference model.
module tb_edge_blip_bank;

  localparam int NI = 3;
  localparam int S_P [NI] = '{2, 3, 2};
  localparam int D_P [NI] = '{4, 3, 1};
  localparam int M_P [NI] = '{0, 2, 1};

  logic       clk = 1'b0;
  logic       resetN;
  logic [4:0] in_lvl, en, clr;
  logic [4:0] lo_o [NI];
  logic [4:0] bl_o [NI];
  logic [4:0] pd_o [NI];
  logic       any_o [NI];

  int checks = 0;
  int errors = 0;

  // Reference model state: every input sample since reset, plus per-bank outputs.
  logic [4:0] hist [$];
  logic [4:0] m_lvl  [NI];
  logic [4:0] m_blip [NI];
  logic [4:0] m_pend [NI];

  always #5 clk = ~clk;

  edge_blip_bank u_a (
    .clk(clk), .resetN(resetN), .inLevel(in_lvl), .chanEn(en), .clrPend(clr),
    .levelOut(lo_o[0]), .blip(bl_o[0]), .pending(pd_o[0]), .anyBlip(any_o[0])
  );

  edge_blip_bank #(.NCH(5), .SYNC_STAGES(3), .DB_CYCLES(3), .EDGE_MODE(2)) u_b (
    .clk(clk), .resetN(resetN), .inLevel(in_lvl), .chanEn(en), .clrPend(clr),
    .levelOut(lo_o[1]), .blip(bl_o[1]), .pending(pd_o[1]), .anyBlip(any_o[1])
  );

  edge_blip_bank #(.NCH(5), .SYNC_STAGES(2), .DB_CYCLES(1), .EDGE_MODE(1)) u_c (
    .clk(clk), .resetN(resetN), .inLevel(in_lvl), .chanEn(en), .clrPend(clr),
    .levelOut(lo_o[2]), .blip(bl_o[2]), .pending(pd_o[2]), .anyBlip(any_o[2])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic mode_ok(input int m, input logic rising);
    return (m == 2) || (m == 0 && rising) || (m == 1 && !rising);
  endfunction

  // Synchronised value seen by the debouncer at edge j: the input sampled
  // s edges earlier (zero before any sample exists).
  function automatic logic sync_at(input int j, input int ch, input int s);
    int idx;
    idx = j - s;
    if (idx < 0) return 1'b0;
    return hist[idx][ch];
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < NI; i++) begin
      m_lvl[i]  = '0;
      m_blip[i] = '0;
      m_pend[i] = '0;
    end
  endtask

  // Advance one clock edge; the level flips once the last DB_CYCLES
  // synchronised samples all disagree with it.
  task automatic step();
    logic [4:0] in_s, en_s, clr_s;
    int k;
    logic tog, nb;
    in_s  = in_lvl;
    en_s  = en;
    clr_s = clr;
    @(posedge clk);
    hist.push_back(in_s);
    k = hist.size() - 1;
    for (int i = 0; i < NI; i++) begin
      for (int ch = 0; ch < 5; ch++) begin
        tog = 1'b1;
        for (int j = k - D_P[i] + 1; j <= k; j++)
          if (sync_at(j, ch, S_P[i]) == m_lvl[i][ch]) tog = 1'b0;
        nb = 1'b0;
        if (tog) begin
          m_lvl[i][ch] = ~m_lvl[i][ch];
          nb = en_s[ch] && mode_ok(M_P[i], m_lvl[i][ch]);
        end
        m_blip[i][ch] = nb;
        m_pend[i][ch] = nb | (m_pend[i][ch] & ~clr_s[ch]);
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    #2 resetN = 1'b0;
    #1 model_clear();
    #1 resetN = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({lo_o[i], bl_o[i], pd_o[i], any_o[i]} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs bank%0d: got lvl=%b blip=%b pend=%b any=%b want all 0",
                 i, lo_o[i], bl_o[i], pd_o[i], any_o[i]);
      end
    end
  endtask

  task automatic test_rise();
    in_lvl[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      checks++;
      if (lo_o[0][0] !== 1'b0) begin
        errors++;
        $display("FAIL rise_early edge%0d: got levelOut[0]=%b want 0", e, lo_o[0][0]);
      end
    end
    step();
    checks++;
    if ({lo_o[0][0], bl_o[0][0], pd_o[0][0], any_o[0]} !== 4'b1111) begin
      errors++;
      $display("FAIL rise_edge6: got lvl=%b blip=%b pend=%b any=%b want 1111",
               lo_o[0][0], bl_o[0][0], pd_o[0][0], any_o[0]);
    end
    step();
    checks++;
    if ({lo_o[0][0], bl_o[0][0], pd_o[0][0]} !== 3'b101) begin
      errors++;
      $display("FAIL rise_edge7: got lvl=%b blip=%b pend=%b want 101",
               lo_o[0][0], bl_o[0][0], pd_o[0][0]);
    end
    repeat (3) step();
    checks++;
    if (pd_o[0][0] !== 1'b1) begin
      errors++;
      $display("FAIL rise_pend_hold: got %b want 1", pd_o[0][0]);
    end
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    checks++;
    if (pd_o[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_pend_clear: got %b want 0", pd_o[0][0]);
    end
  endtask

  task automatic test_glitch();
    in_lvl[1] = 1'b1;
    repeat (3) step();
    in_lvl[1] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if ({lo_o[0][1], bl_o[0][1], pd_o[0][1]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch cyc%0d: got lvl=%b blip=%b pend=%b want 000",
                 e, lo_o[0][1], bl_o[0][1], pd_o[0][1]);
      end
    end
  endtask

  task automatic test_both();
    int t [$];
    in_lvl[2] = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 11) in_lvl[2] = 1'b0;
      step();
      if (bl_o[1][2] === 1'b1) t.push_back(cyc);
    end
    checks++;
    if (t.size() != 2) begin
      errors++;
      $display("FAIL both_count: got %0d blips want 2", t.size());
    end else begin
      checks++;
      if (t[1] - t[0] != 10) begin
        errors++;
        $display("FAIL both_gap: got %0d cycles want 10", t[1] - t[0]);
      end
    end
  endtask

  task automatic test_enable();
    int nb = 0;
    en[3] = 1'b0;
    in_lvl[3] = 1'b1;
    repeat (8) begin
      step();
      if (bl_o[0][3] !== 1'b0) nb++;
    end
    checks++;
    if (nb != 0 || lo_o[0][3] !== 1'b1 || pd_o[0][3] !== 1'b0) begin
      errors++;
      $display("FAIL enable_off: got blips=%0d lvl=%b pend=%b want 0 1 0",
               nb, lo_o[0][3], pd_o[0][3]);
    end
    in_lvl[3] = 1'b0;
    repeat (8) step();
    en[3] = 1'b1;
    in_lvl[3] = 1'b1;
    repeat (5) step();
    checks++;
    if (lo_o[0][3] !== 1'b0) begin
      errors++;
      $display("FAIL enable_early: got lvl=%b want 0", lo_o[0][3]);
    end
    clr[3] = 1'b1;
    step();
    clr[3] = 1'b0;
    checks++;
    if ({bl_o[0][3], pd_o[0][3]} !== 2'b11) begin
      errors++;
      $display("FAIL enable_set_wins: got blip=%b pend=%b want 11", bl_o[0][3], pd_o[0][3]);
    end
    step();
    checks++;
    if (pd_o[0][3] !== 1'b1) begin
      errors++;
      $display("FAIL enable_pend_hold: got %b want 1", pd_o[0][3]);
    end
  endtask

  task automatic test_reset_mid();
    in_lvl[4] = 1'b1;
    repeat (4) step();
    #2 resetN = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({lo_o[i], bl_o[i], pd_o[i], any_o[i]} !== 16'h0) begin
        errors++;
        $display("FAIL reset_mid bank%0d: got lvl=%b blip=%b pend=%b any=%b want all 0",
                 i, lo_o[i], bl_o[i], pd_o[i], any_o[i]);
      end
    end
    model_clear();
    #1 resetN = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (bl_o[0][4] !== (e == 6)) begin
        errors++;
        $display("FAIL reset_release edge%0d: got blip[4]=%b want %b", e, bl_o[0][4], e == 6);
      end
    end
  endtask

  task automatic test_all_rise();
    int nfull = 0, nany = 0, bad = 0;
    in_lvl = '0;
    en = '1;
    clr = '1;
    repeat (8) step();
    clr = '0;
    in_lvl = 5'h1f;
    repeat (10) begin
      step();
      if (bl_o[0] === 5'h1f) nfull++;
      if (any_o[0] === 1'b1) nany++;
      if (bl_o[0] !== 5'h00 && bl_o[0] !== 5'h1f) bad++;
    end
    checks++;
    if (nfull != 1 || nany != 1 || bad != 0) begin
      errors++;
      $display("FAIL all_rise: got full=%0d any=%0d partial=%0d want 1 1 0", nfull, nany, bad);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if ($urandom_range(0, 5) == 0) in_lvl[ch] = ~in_lvl[ch];
        if ($urandom_range(0, 40) == 0) en[ch] = ~en[ch];
        clr[ch] = ($urandom_range(0, 3) == 0);
      end
      step();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (lo_o[i] !== m_lvl[i] || bl_o[i] !== m_blip[i] || pd_o[i] !== m_pend[i] ||
            any_o[i] !== (|m_blip[i])) begin
          errors++;
          $display("FAIL random bank%0d cyc%0d: got lvl=%b blip=%b pend=%b any=%b want %b %b %b %b",
                   i, cyc, lo_o[i], bl_o[i], pd_o[i], any_o[i],
                   m_lvl[i], m_blip[i], m_pend[i], |m_blip[i]);
        end
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    in_lvl = '0;
    en     = '1;
    clr    = '0;
    model_clear();
    #22;
    test_reset();
    resetN = 1'b1;
    test_rise();
    test_glitch();
    test_both();
    test_enable();
    test_reset_mid();
    test_all_rise();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_blip_bank.md
EDGE_BLIP_BANK -- requirements
Module: edge_blip_bank

Interface
REQ-001 Parameter NCH, default 5: number of independent input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal range 2..4.
REQ-003 Parameter DB_CYCLES, default 4: consecutive synchronised cycles a new level must hold before acceptance, legal range 1..255.
REQ-004 Parameter EDGE_MODE, default 0: edge that generates a blip; 0 = rising, 1 = falling, 2 = both.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port resetN, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port inLevel, input, NCH: raw, possibly asynchronous, level inputs.
REQ-008 Port chanEn, input, NCH: per-channel enable for blip and pending outputs.
REQ-009 Port clrPend, input, NCH: per-channel pending-flag clear, sampled each clock.
REQ-010 Port levelOut, output, NCH: debounced, synchronised level.
REQ-011 Port blip, output, NCH: single-cycle edge pulse, registered.
REQ-012 Port pending, output, NCH: sticky edge-seen flag.
REQ-013 Port anyBlip, output, 1: OR of all bits of blip.

Function
REQ-014 Each channel SHALL pass inLevel through a SYNC_STAGES-deep flop chain; only the last stage is used downstream.
REQ-015 Per channel, a debounce counter (width ceil(log2(DB_CYCLES+1))) SHALL clear whenever the synchronised level equals levelOut, and increment otherwise.
REQ-016 When the counter would reach DB_CYCLES, levelOut SHALL toggle on that edge and the counter SHALL clear; the counter never exceeds DB_CYCLES-1 and never wraps.
REQ-017 Latency: a clean input change first sampled on edge 1 SHALL appear on levelOut after edge SYNC_STAGES+DB_CYCLES (edge 6 at defaults).
REQ-018 An input pulse or glitch lasting fewer than DB_CYCLES synchronised cycles SHALL leave levelOut, blip and pending unchanged.
REQ-019 blip[i] SHALL be 1 for exactly the one cycle in which levelOut[i] first shows its new value, and only when the transition matches EDGE_MODE and chanEn[i]=1 on that edge.
REQ-020 blip[i] SHALL be 0 in every other cycle; a level held indefinitely produces no further blips.
REQ-021 chanEn[i]=0 SHALL suppress blip[i] and the setting of pending[i]; levelOut[i] SHALL still track the input.
REQ-022 pending[i] SHALL set on any edge where blip[i] becomes 1, clear on an edge with clrPend[i]=1, and otherwise hold.
REQ-023 Simultaneous set and clrPend[i] on the same edge SHALL leave pending[i]=1 (set wins).
REQ-024 anyBlip SHALL be the combinational OR of the registered blip vector, adding no latency.
REQ-025 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each produce their own blip in the same cycle.

Reset
REQ-026 resetN=0 SHALL asynchronously clear all synchroniser flops, debounce counters, levelOut, blip and pending to 0, so anyBlip=0.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count with no blip on release.
REQ-028 After release with inLevel high, the channel SHALL treat it as a rising edge and blip after the REQ-017 latency, matching power-up-from-zero behaviour.

Structure
REQ-029 Package edge_blip_pkg SHALL hold EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2 and the maximum-width constants.
REQ-030 One sub-module, edge_blip_chan (synchroniser, debounce, edge detect, pending), SHALL be instantiated NCH times by a generate loop; the top holds only instances and the anyBlip OR.

Verification
REQ-031 Defaults, inLevel[0] 0->1 held -> levelOut[0]=1 and blip[0]=1 after edge 6, blip[0]=0 after edge 7, pending[0]=1 until clrPend[0].
REQ-032 Defaults, inLevel[1] high for 3 cycles then low -> no change on levelOut[1], blip[1] or pending[1].
REQ-033 EDGE_MODE=2, ch2 toggles 0->1->0 with each level held 10 cycles -> exactly two blip[2] pulses, 10 cycles apart.
REQ-034 chanEn[3]=0, ch3 rises -> levelOut[3]=1, blip[3]=0, pending[3]=0; repeat with chanEn[3]=1 and clrPend[3]=1 on the blip edge -> pending[3]=1.
REQ-035 Assert resetN=0 two cycles into debounce on ch4 -> all outputs 0 immediately; release with inLevel[4]=1 -> blip[4] after 6 edges.
REQ-036 Rise all 5 channels together -> blip=5'b11111 and anyBlip=1 for exactly one cycle.
